// File: rtl/uart_tx_arbiter_pkg.sv
// Shared UART definitions: data width, arbiter state encoding and a
// small index helper. Also intended for the future uart_rx block.
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_BUSY = 2'd1,
        WAIT_DONE = 2'd2
    } arb_state_t;

    // Next index after idx, wrapping from n-1 back to 0.
    function automatic int wrap_inc(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: returns the first asserted request
// found scanning upward from ptr, wrapping from N-1 to 0.
module rr_pick #(
    parameter int N = 4,
    parameter int W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] sel,
    output logic         any
);

    // Requester index that sits k places after ptr.
    function automatic logic [W-1:0] rot_index(input logic [W-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= N) begin
            s = s - N;
        end
        return W'(s);
    endfunction

    // rot[k] is the request that sits k places after ptr in scan order.
    logic [N-1:0] rot;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_rot
            assign rot[gi] = req[rot_index(ptr, gi)];
        end
    endgenerate

    // Lowest rotated position wins; scanning downward lets it overwrite.
    always_comb begin
        sel = ptr;
        any = 1'b0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                sel = rot_index(ptr, k);
                any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, packet-locking arbiter that shares one uart_tx serializer
// among NUM_REQ byte producers. One byte in flight at a time: accept,
// pulse start, wait for busy to rise, wait for busy to fall.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter  int NUM_REQ      = 4,
    parameter  int BUSY_TIMEOUT = 8,
    localparam int ID_W         = $clog2(NUM_REQ)
) (
    input  logic                           clock,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    input  logic [UART_DATA_W*NUM_REQ-1:0] req_data,
    input  logic [NUM_REQ-1:0]             req_last,
    output logic [NUM_REQ-1:0]             req_ready,
    output logic                           tx_start,
    output logic [UART_DATA_W-1:0]         tx_data,
    input  logic                           tx_busy,
    output logic [ID_W-1:0]                grant_id,
    output logic                           locked,
    output logic                           err_timeout
);

    localparam int CNT_W = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    arb_state_t             state_reg;
    logic [CNT_W-1:0]       wait_cnt_reg;
    logic [ID_W-1:0]        rr_ptr_reg;
    logic                   last_reg;

    logic [ID_W-1:0]        pick_sel;
    logic                   pick_any;
    logic [ID_W-1:0]        sel;
    logic                   sel_valid;
    logic                   sel_last;
    logic [UART_DATA_W-1:0] sel_byte;
    logic                   accept;
    logic [ID_W-1:0]        rr_ptr_next;

    rr_pick #(
        .N (NUM_REQ),
        .W (ID_W)
    ) u_pick (
        .req (req_valid),
        .ptr (rr_ptr_reg),
        .sel (pick_sel),
        .any (pick_any)
    );

    // A locked packet pins selection to its owner; otherwise round-robin.
    always_comb begin
        sel       = locked ? grant_id : pick_sel;
        sel_valid = locked ? req_valid[grant_id] : pick_any;
        sel_last  = req_last[sel];
    end

    // Byte mux for the selected requester.
    always_comb begin
        sel_byte = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (sel == ID_W'(i)) begin
                sel_byte = req_data[i*UART_DATA_W +: UART_DATA_W];
            end
        end
    end

    // Ready only in IDLE with the serializer free; a late or stuck busy
    // holds every producer off.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_ready
            assign req_ready[gi] = (state_reg == IDLE) && !tx_busy && sel_valid
                                   && (sel == ID_W'(gi)) && req_valid[gi];
        end
    endgenerate

    assign accept      = |(req_valid & req_ready);
    assign rr_ptr_next = ID_W'(wrap_inc(int'(grant_id), NUM_REQ));

    // Arbiter FSM with registered serializer controls and status outputs.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_reg    <= IDLE;
            wait_cnt_reg <= '0;
            rr_ptr_reg   <= '0;
            last_reg     <= 1'b0;
            tx_start     <= 1'b0;
            tx_data      <= '0;
            grant_id     <= '0;
            locked       <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            tx_start    <= 1'b0;
            err_timeout <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        tx_data      <= sel_byte;
                        tx_start     <= 1'b1;
                        grant_id     <= sel;
                        locked       <= !sel_last;
                        last_reg     <= sel_last;
                        wait_cnt_reg <= '0;
                        state_reg    <= WAIT_BUSY;
                    end
                end
                WAIT_BUSY: begin
                    if (tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end else if (wait_cnt_reg == CNT_W'(BUSY_TIMEOUT - 1)) begin
                        // Serializer never answered: drop the packet and move on.
                        err_timeout <= 1'b1;
                        locked      <= 1'b0;
                        rr_ptr_reg  <= rr_ptr_next;
                        state_reg   <= IDLE;
                    end else begin
                        wait_cnt_reg <= wait_cnt_reg + CNT_W'(1);
                    end
                end
                WAIT_DONE: begin
                    if (!tx_busy) begin
                        // Pointer only moves at packet end, never per byte.
                        if (last_reg) begin
                            rr_ptr_reg <= rr_ptr_next;
                        end
                        state_reg <= IDLE;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a simple busy model of uart_tx.
module tb_uart_tx_arbiter;

    localparam int NUM_REQ      = 4;
    localparam int BUSY_TIMEOUT = 8;
    localparam int FRAME        = 6;

    logic        clock;
    logic        reset;
    logic [3:0]  req_valid;
    logic [31:0] req_data;
    logic [3:0]  req_last;
    logic [3:0]  req_ready;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        locked;
    logic        err_timeout;

    int n_checks = 0;
    int n_fail   = 0;

    logic model_en;
    int   busy_cnt;

    uart_tx_arbiter #(
        .NUM_REQ      (NUM_REQ),
        .BUSY_TIMEOUT (BUSY_TIMEOUT)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .req_valid   (req_valid),
        .req_data    (req_data),
        .req_last    (req_last),
        .req_ready   (req_ready),
        .tx_start    (tx_start),
        .tx_data     (tx_data),
        .tx_busy     (tx_busy),
        .grant_id    (grant_id),
        .locked      (locked),
        .err_timeout (err_timeout)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Serializer model: busy for FRAME cycles after sampling start.
    always @(posedge clock or posedge reset) begin
        if (reset) busy_cnt <= 0;
        else if (tx_start && model_en) busy_cnt <= FRAME;
        else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
    assign tx_busy = (busy_cnt != 0);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end else begin
            $display("ok   %s: %0h", name, act);
        end
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_tx_start"}, 32'(tx_start), 32'h0);
        check({tag, "_tx_data"}, 32'(tx_data), 32'h00);
        check({tag, "_grant_id"}, 32'(grant_id), 32'h0);
        check({tag, "_locked"}, 32'(locked), 32'h0);
        check({tag, "_err_timeout"}, 32'(err_timeout), 32'h0);
        check({tag, "_req_ready"}, 32'(req_ready), 32'h0);
    endtask

    // Wait for busy to rise then fall, then one edge for the arbiter to reach IDLE.
    task automatic wait_frame_done(input string name);
        int n;
        n = 0;
        while (!tx_busy && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 50) begin
            check({name, "_busy_rise_timeout"}, 32'(n), 32'd0);
            return;
        end
        check({name, "_ready_mid_frame"}, 32'(req_ready), 32'h0);
        n = 0;
        while (tx_busy && n < 50) begin
            @(posedge clock); #1; n++;
        end
        if (n >= 50) check({name, "_busy_fall_timeout"}, 32'(n), 32'd0);
        @(posedge clock); #1;
    endtask

    // Offer a set of valids, wait for the accept, check the grant and the
    // registered outputs, retire the winning byte, then wait out the frame.
    task automatic serve(input logic [3:0] v, input logic [3:0] l, input logic [31:0] d,
                         input int exp_id, input logic [7:0] exp_data, input logic exp_lk,
                         input string name);
        int n;
        logic [3:0] rdy_exp;
        @(negedge clock);
        req_valid = v;
        req_last  = l;
        req_data  = d;
        #1;
        n = 0;
        while (!(|(req_valid & req_ready)) && n < 200) begin
            @(negedge clock); #1; n++;
        end
        if (n >= 200) begin
            check({name, "_accept_timeout"}, 32'(n), 32'd0);
            return;
        end
        rdy_exp = 4'b0001 << exp_id;
        check({name, "_ready"}, 32'(req_ready), 32'(rdy_exp));
        @(posedge clock); #1;
        check({name, "_tx_start"}, 32'(tx_start), 32'h1);
        check({name, "_tx_data"}, 32'(tx_data), 32'(exp_data));
        check({name, "_grant_id"}, 32'(grant_id), 32'(exp_id));
        check({name, "_locked"}, 32'(locked), 32'(exp_lk));
        req_valid = req_valid & ~rdy_exp;
        @(posedge clock); #1;
        check({name, "_start_pulse_end"}, 32'(tx_start), 32'h0);
        wait_frame_done(name);
    endtask

    typedef struct {
        logic [3:0]  v;
        logic [3:0]  l;
        logic [31:0] d;
        int          id;
        logic [7:0]  dat;
        logic        lk;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int n;
        // Round-robin sequence (all single-byte packets), then a locked
        // three-byte packet from req2 with req0 waiting throughout.
        vecs[0]  = '{4'b0001, 4'b1111, 32'h000000A5, 0, 8'hA5, 1'b0};
        vecs[1]  = '{4'b0011, 4'b1111, 32'h0000C1C0, 1, 8'hC1, 1'b0};
        vecs[2]  = '{4'b1001, 4'b1111, 32'hD30000C0, 3, 8'hD3, 1'b0};
        vecs[3]  = '{4'b0011, 4'b1111, 32'h0000E1E0, 0, 8'hE0, 1'b0};
        vecs[4]  = '{4'b0110, 4'b1111, 32'h00F2F100, 1, 8'hF1, 1'b0};
        vecs[5]  = '{4'b0111, 4'b1111, 32'h00222120, 2, 8'h22, 1'b0};
        vecs[6]  = '{4'b0001, 4'b1111, 32'h00000030, 0, 8'h30, 1'b0};
        vecs[7]  = '{4'b0101, 4'b0000, 32'h00410040, 2, 8'h41, 1'b1};
        vecs[8]  = '{4'b0101, 4'b0000, 32'h00420040, 2, 8'h42, 1'b1};
        vecs[9]  = '{4'b0101, 4'b0100, 32'h00430040, 2, 8'h43, 1'b0};
        vecs[10] = '{4'b0001, 4'b0001, 32'h00000040, 0, 8'h40, 1'b0};

        model_en  = 1'b1;
        reset     = 1'b1;
        req_valid = '0;
        req_last  = '0;
        req_data  = '0;
        repeat (3) @(posedge clock);
        #1;
        check_reset_values("reset");
        @(negedge clock);
        reset = 1'b0;

        for (int i = 0; i < 11; i++) begin
            serve(vecs[i].v, vecs[i].l, vecs[i].d, vecs[i].id, vecs[i].dat, vecs[i].lk,
                  $sformatf("vec%0d", i));
        end

        // Owner stall: req1 opens a packet, then goes quiet while others ask.
        serve(4'b0010, 4'b0000, 32'h00005100, 1, 8'h51, 1'b1, "stall_first");
        @(negedge clock);
        req_valid = 4'b1101;
        req_last  = 4'b1111;
        for (int c = 0; c < 50; c++) begin
            @(negedge clock); #1;
            if (c % 10 == 0) check($sformatf("stall_ready_c%0d", c), 32'(req_ready), 32'h0);
        end
        check("stall_grant_id", 32'(grant_id), 32'h1);
        check("stall_locked", 32'(locked), 32'h1);
        serve(4'b1111, 4'b1111, 32'h63625260, 1, 8'h52, 1'b0, "stall_resume");
        serve(4'b1101, 4'b1111, 32'h63620060, 2, 8'h62, 1'b0, "after_stall");

        // Timeout: serializer silent, req1 sends 3C; req3 waits behind it.
        model_en = 1'b0;
        @(negedge clock);
        req_valid = 4'b0010;
        req_last  = 4'b0010;
        req_data  = 32'h00003C00;
        #1;
        n = 0;
        while (!(|(req_valid & req_ready)) && n < 50) begin
            @(negedge clock); #1; n++;
        end
        check("to_ready", 32'(req_ready), 32'h2);
        @(posedge clock); #1;
        check("to_tx_start", 32'(tx_start), 32'h1);
        check("to_tx_data", 32'(tx_data), 32'h3C);
        req_valid = 4'b1000;
        req_last  = 4'b1000;
        req_data  = 32'h77000000;
        n = 0;
        while (!err_timeout && n < 50) begin
            @(posedge clock); #1; n++;
        end
        check("to_latency", 32'(n), 32'(BUSY_TIMEOUT));
        check("to_locked", 32'(locked), 32'h0);
        check("to_idle_ready", 32'(req_ready), 32'h8);
        model_en = 1'b1;
        @(posedge clock); #1;
        check("to_err_pulse_end", 32'(err_timeout), 32'h0);
        check("to_next_start", 32'(tx_start), 32'h1);
        check("to_next_grant", 32'(grant_id), 32'h3);
        check("to_next_data", 32'(tx_data), 32'h77);
        req_valid = '0;
        wait_frame_done("to_next");

        // Reset in WAIT_DONE of a locked packet from req2.
        serve(4'b0010, 4'b0010, 32'h00008100, 1, 8'h81, 1'b0, "pre_reset");
        serve(4'b0100, 4'b0000, 32'h00920000, 2, 8'h92, 1'b1, "rst_pkt_start_skip_wait");
        serve(4'b0100, 4'b0000, 32'h00930000, 2, 8'h93, 1'b1, "rst_pkt_byte2");
        @(negedge clock);
        req_valid = 4'b0100;
        req_last  = 4'b0000;
        req_data  = 32'h00940000;
        #1;
        n = 0;
        while (!(|(req_valid & req_ready)) && n < 50) begin
            @(negedge clock); #1; n++;
        end
        @(posedge clock); #1;
        req_valid = '0;
        check("rst_locked_before", 32'(locked), 32'h1);
        n = 0;
        while (!tx_busy && n < 50) begin
            @(posedge clock); #1; n++;
        end
        @(posedge clock); #1;
        @(posedge clock); #1;
        check("rst_busy_before", 32'(tx_busy), 32'h1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_values("midrst");
        @(negedge clock);
        reset = 1'b0;
        serve(4'b1111, 4'b1111, 32'h44332211, 0, 8'h11, 1'b0, "post_reset");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Global time guard so the run always ends.
    initial begin
        #200000;
        $display("FAIL global_timeout: got simulation still running expected finished");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Shares one `uart_tx` serializer among `NUM_REQ` byte producers (debug console, status reporter, command echo, …). Each producer offers bytes on a valid/ready handshake. The arbiter picks one by round-robin and holds the grant for the whole packet, up to and including the byte marked `last`. It then drives the serializer's `start`/`data_in` and tracks its `busy` until the frame is done. It sits directly between the producers and the single `uart_tx` instance at the chip top.

## Interface
- `NUM_REQ`, 4: number of requesters, 2..8.
- `BUSY_TIMEOUT`, 8: cycles to wait for `tx_busy` to rise after `tx_start` before declaring an error.
- `clock`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high.
- `req_valid`  in  NUM_REQ  bit i: requester i offers a byte.
- `req_data`  in  8*NUM_REQ  byte i in bits [8i+7:8i].
- `req_last`  in  NUM_REQ  bit i: offered byte ends requester i's packet.
- `req_ready`  out  NUM_REQ  one-hot or zero; the byte transfers in a cycle where `req_valid[i] && req_ready[i]`.
- `tx_start`  out  1  to `uart_tx.start`; registered one-cycle pulse.
- `tx_data`  out  8  to `uart_tx.data_in`; registered, held until the next accept.
- `tx_busy`  in  1  from `uart_tx.busy`.
- `grant_id`  out  clog2(NUM_REQ)  index of the current or last owner.
- `locked`  out  1  a packet is in progress; only `grant_id` may be served.
- `err_timeout`  out  1  one-cycle pulse when `tx_busy` never rose.

## Operation
- States:
  - IDLE: wait for a serviceable requester.
  - WAIT_BUSY: start issued; wait for `tx_busy` to rise.
  - WAIT_DONE: wait for `tx_busy` to fall.
- `req_ready[i]` is combinational: `state==IDLE && !tx_busy && i==sel && req_valid[i]`.
- `sel` when `locked`: `grant_id`. If the owner deasserts valid, the arbiter waits indefinitely. There is no preemption.
- `sel` when not locked: first asserted `req_valid` scanning upward from `rr_ptr`, wrapping from NUM_REQ-1 to 0.
- On accept:
  - next edge sets `tx_data<=byte`, `tx_start<=1`, `grant_id<=sel`, `locked<=!req_last[sel]`, and latches `last_r<=req_last[sel]`.
  - state moves to WAIT_BUSY.
- WAIT_BUSY:
  - `tx_start` clears after one cycle.
  - A wait counter counts cycles from 0.
  - On `tx_busy==1`, move to WAIT_DONE.
  - If the counter reaches BUSY_TIMEOUT-1 with `tx_busy` still low: pulse `err_timeout`, clear `locked`, set `rr_ptr<=grant_id+1` (mod NUM_REQ), and return to IDLE.
- WAIT_DONE:
  - On `tx_busy==0`, return to IDLE.
  - If `last_r`, set `rr_ptr<=grant_id+1` (mod NUM_REQ). `locked` is already 0.
- `rr_ptr` advances only at packet end or on timeout, never per byte inside a packet.
- Reset values:
  - `tx_start=0`, `tx_data=8'h00`, `grant_id=0`, `locked=0`, `err_timeout=0`, `req_ready=0`.
  - `rr_ptr=0`, state IDLE, wait counter 0.
- Reset mid-frame aborts the packet. The shared `reset` also returns `uart_tx` to idle.
- `tx_busy` high while the arbiter is in IDLE (e.g. after a timeout, or when the serializer is late): no accept until it falls.

## Timing
- Accept at edge E. `tx_start=1` during cycle E+1. `uart_tx` samples it at E+2 and `busy` goes high. The arbiter sees `tx_busy` at E+2 and enters WAIT_DONE at E+3.
- `tx_busy` falls at the end of STOP. The arbiter is back in IDLE one edge later. The earliest next accept is the cycle after that.
- Throughput is 10·CLOCK_DIV of `uart_tx` plus 4 cycles per byte.
- Simultaneous valids with `rr_ptr=2`, NUM_REQ=4: scan order is 2, 3, 0, 1.

## Structure
- Package `uart_pkg`:
  - state enum `arb_state_t` (IDLE, WAIT_BUSY, WAIT_DONE).
  - `UART_DATA_W=8`.
  - shared with future `uart_rx`.
- Sub-module `rr_pick`: combinational.
  - Inputs: `req` vector and `ptr`.
  - Outputs: `sel` index and `any` bit.
  - Reused by later arbiters.

## Test plan
- Single byte: req0 sends 8'hA5 with last. Check: one `tx_start` pulse 1 cycle after accept, `tx_data=8'hA5`, `req_ready` low until `busy` falls, `rr_ptr=1`.
- Contention: req1 and req3 valid together from reset. Order is 1 then 3. Then req1 again and req0 together: req0 is served first (`rr_ptr=0` after wrap).
- Packet lock: req2 sends 3 bytes with last on the third while req0 stays valid. req0 gets no ready until the third byte completes; `locked` reads 1, 1, 0.
- Timeout: `tx_busy` tied 0, req1 sends 8'h3C. `err_timeout` pulses exactly BUSY_TIMEOUT cycles after `tx_start`, `locked=0`, state IDLE.
- Reset mid-frame: assert `reset` in WAIT_DONE of a locked packet. All outputs return to reset values immediately, and the next grant starts at requester 0.
- Owner stall: the locked owner drops valid for 50 cycles while others request. There is no grant change, and the owner is served when it resumes.
